// File: rtl/store_narrow_unit.sv
// Store narrowing unit: positions a byte/half/word store onto a word-addressed
// write port with byte enables, splitting word-crossing stores into two beats.
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_WR1,
        S_FIN,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic              wrEn_q, wrEn_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] b1Addr_q, b1Addr_d;
    logic [31:0]       b1Data_q, b1Data_d;
    logic [3:0]        b1Be_q, b1Be_d;

    logic [31:0]       sizeMask;
    logic [3:0]        laneMask;
    logic [63:0]       shiftData;
    logic [7:0]        shiftBe;
    logic [ADDR_W-1:0] baseAddr;

    // The second beat is precomputed at capture so only its lanes need storing.
    always_comb begin
        sizeMask = 32'h0;
        laneMask = 4'b0000;
        case (req_size)
            2'b00:   begin sizeMask = 32'h0000_00FF; laneMask = 4'b0001; end
            2'b01:   begin sizeMask = 32'h0000_FFFF; laneMask = 4'b0011; end
            2'b10:   begin sizeMask = 32'hFFFF_FFFF; laneMask = 4'b1111; end
            default: begin sizeMask = 32'h0;         laneMask = 4'b0000; end
        endcase
        shiftData = {32'h0, req_data & sizeMask} << {req_addr[1:0], 3'b000};
        shiftBe   = {4'b0000, laneMask} << req_addr[1:0];
        baseAddr  = {req_addr[ADDR_W-1:2], 2'b00};
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        wrEn_d    = 1'b0;
        memAddr_d = '0;
        wdata_d   = 32'h0;
        be_d      = 4'b0000;
        done_d    = 1'b0;
        err_d     = 1'b0;
        b1Addr_d  = b1Addr_q;
        b1Data_d  = b1Data_q;
        b1Be_d    = b1Be_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (req_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (req_size == 2'b11) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_WR0;
                        wrEn_d    = 1'b1;
                        memAddr_d = baseAddr;
                        wdata_d   = shiftData[31:0];
                        be_d      = shiftBe[3:0];
                        b1Addr_d  = baseAddr + ADDR_W'(4);
                        b1Data_d  = shiftData[63:32];
                        b1Be_d    = shiftBe[7:4];
                    end
                end
            end
            S_WR0: begin
                if (mem_ack && (b1Be_q != 4'b0000)) begin
                    state_d   = S_WR1;
                    wrEn_d    = 1'b1;
                    memAddr_d = b1Addr_q;
                    wdata_d   = b1Data_q;
                    be_d      = b1Be_q;
                end else if (mem_ack) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    wrEn_d    = 1'b1;
                    memAddr_d = memAddr_q;
                    wdata_d   = wdata_q;
                    be_d      = be_q;
                end
            end
            S_WR1: begin
                if (mem_ack) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    wrEn_d    = 1'b1;
                    memAddr_d = memAddr_q;
                    wdata_d   = wdata_q;
                    be_d      = be_q;
                end
            end
            S_FIN, S_ERR: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            wrEn_q    <= 1'b0;
            memAddr_q <= '0;
            wdata_q   <= 32'h0;
            be_q      <= 4'b0000;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            b1Addr_q  <= '0;
            b1Data_q  <= 32'h0;
            b1Be_q    <= 4'b0000;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            wrEn_q    <= wrEn_d;
            memAddr_q <= memAddr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            done_q    <= done_d;
            err_q     <= err_d;
            b1Addr_q  <= b1Addr_d;
            b1Data_q  <= b1Data_d;
            b1Be_q    <= b1Be_d;
        end
    end

    assign req_ready = ready_q;
    assign mem_wr_en = wrEn_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Randomized self-checking bench for store_narrow_unit; expected beats come
// from a byte-by-byte placement model of the store.
module tb_store_narrow_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        err;

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] eAddr [2];
    logic [31:0] eData [2];
    logic [3:0]  eBe   [2];
    int          eBeats;
    bit          eErr;

    store_narrow_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Each stored byte lands in the word holding its own byte address.
    task automatic buildExpect(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        int          nBytes;
        logic [31:0] base;
        logic [31:0] ba;
        int          beat;
        int          lane;
        nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        eErr   = (size == 2'd3);
        base   = addr & ~32'h3;
        eAddr[0] = base;
        eAddr[1] = base + 32'd4;
        for (int b = 0; b < 2; b++) begin
            eData[b] = 32'h0;
            eBe[b]   = 4'b0000;
        end
        for (int k = 0; k < nBytes; k++) begin
            ba   = addr + 32'(k);
            beat = ((ba & ~32'h3) == base) ? 0 : 1;
            lane = int'(ba[1:0]);
            eBe[beat][lane] = 1'b1;
            eData[beat][8*lane +: 8] = data[8*k +: 8];
        end
        eBeats = (eBe[1] != 4'b0000) ? 2 : 1;
    endtask

    task automatic checkBeat(input int b);
        checkOutput($sformatf("beat%0d_wr_en", b), 64'(mem_wr_en), 64'(1));
        checkOutput($sformatf("beat%0d_addr", b),  64'(mem_addr),  64'(eAddr[b]));
        checkOutput($sformatf("beat%0d_be", b),    64'(mem_be),    64'(eBe[b]));
        checkOutput($sformatf("beat%0d_wdata", b), 64'(mem_wdata), 64'(eData[b]));
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                                 input int stall0, input int stall1);
        int stalls [2];
        stalls[0] = stall0;
        stalls[1] = stall1;
        buildExpect(addr, data, size);
        @(negedge clk);
        checkOutput("ready_before_req", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        @(posedge clk);
        #1;
        req_valid = $urandom_range(0, 1);
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        if (eErr) begin
            checkOutput("err_wr_en", 64'(mem_wr_en), 64'(0));
            checkOutput("err_done",  64'(done),      64'(1));
            checkOutput("err_err",   64'(err),       64'(1));
            checkOutput("err_ready", 64'(req_ready), 64'(0));
        end else begin
            for (int b = 0; b < eBeats; b++) begin
                for (int c = 0; c <= stalls[b]; c++) begin
                    checkBeat(b);
                    mem_ack = (c == stalls[b]);
                    @(posedge clk);
                    #1;
                end
            end
            checkOutput("fin_wr_en", 64'(mem_wr_en), 64'(0));
            checkOutput("fin_done",  64'(done),      64'(1));
            checkOutput("fin_err",   64'(err),       64'(0));
            checkOutput("fin_ready", 64'(req_ready), 64'(0));
            mem_ack = $urandom_range(0, 1);
        end
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        checkOutput("idle_ready", 64'(req_ready), 64'(1));
        checkOutput("idle_done",  64'(done),      64'(0));
        checkOutput("idle_err",   64'(err),       64'(0));
        checkOutput("idle_wr_en", 64'(mem_wr_en), 64'(0));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_en"}, 64'(mem_wr_en), 64'(0));
        checkOutput({tag, "_addr"},  64'(mem_addr),  64'(0));
        checkOutput({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
        checkOutput({tag, "_be"},    64'(mem_be),    64'(0));
        checkOutput({tag, "_done"},  64'(done),      64'(0));
        checkOutput({tag, "_err"},   64'(err),       64'(0));
        checkOutput({tag, "_ready"}, 64'(req_ready), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_size  = 2'b00;
        mem_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_reset", 64'(req_ready), 64'(1));

        applyStimulus(32'h0000_1002, 32'h1234_56AB, 2'b00, 0, 0);
        applyStimulus(32'h0000_1003, 32'hAABB_CCDD, 2'b10, 0, 0);
        applyStimulus(32'h0000_2003, 32'hFFFF_BEEF, 2'b01, 3, 0);
        applyStimulus(32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 0, 1);
        applyStimulus(32'h0000_3000, 32'hDEAD_BEEF, 2'b11, 0, 0);
        applyStimulus(32'hFFFF_FFFF, 32'hCAFE_F00D, 2'b01, 1, 2);

        // Reset in the middle of a stalled first beat of a split word store.
        buildExpect(32'h0000_4001, 32'h0102_0304, 2'b10);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_4001;
        req_data  = 32'h0102_0304;
        req_size  = 2'b10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkBeat(0);
        @(posedge clk);
        #1;
        checkBeat(0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_midreset", 64'(req_ready), 64'(1));
        for (int i = 0; i < 3; i++) begin
            checkOutput("no_beat1_after_reset", 64'(mem_wr_en), 64'(0));
            checkOutput("no_done_after_reset",  64'(done),      64'(0));
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        applyStimulus(32'h0000_4001, 32'h0102_0304, 2'b10, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rSize;
            logic [31:0] rAddr;
            rSize = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rAddr = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
            applyStimulus(rAddr, $urandom, rSize, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side counterpart to the load-path sign/zero extender. It accepts a 32-bit register value plus a byte address and an access size (byte, halfword or word), and narrows and positions that value onto a 32-bit word-addressed data memory write port with byte enables. Misaligned stores that cross a word boundary are split into two sequential word writes. It sits between the CPU's execute/memory stage and the data memory, using a valid/ready request side and a write/ack memory side.

## Interface
- `ADDR_W`, default 32: byte-address width. All address arithmetic is modulo 2^ADDR_W.
- `clk`, in, 1: single clock, rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, 1: store request present.
- `req_ready`, out, 1: unit can accept a request. High only in IDLE.
- `req_addr`, in, ADDR_W: byte address.
- `req_data`, in, 32: source register value. Only the low 8/16/32 bits are used, according to size.
- `req_size`, in, 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `mem_wr_en`, out, 1: write beat valid.
- `mem_addr`, out, ADDR_W: word-aligned address, low 2 bits always 0.
- `mem_wdata`, out, 32: positioned write data. Non-enabled lanes are driven to 0.
- `mem_be`, out, 4: byte enables. Bit i covers `mem_wdata[8i+7:8i]`.
- `mem_ack`, in, 1: memory accepts the current beat.
- `done`, out, 1: one-cycle pulse when the request completes.
- `err`, out, 1: one-cycle pulse, coincident with `done`, for a reserved size.

## Operation
- **Request capture.**
  - Handshake on `req_valid && req_ready`.
  - `req_addr`, `req_data` and `req_size` are registered at the handshake. Inputs are ignored at all other times.
- **Lane placement.** Little-endian, with off = `addr[1:0]`.
  - mask = 0001 for byte, 0011 for half, 1111 for word.
  - Shifted data: 64-bit `{32'b0, data & size_mask} << 8*off`.
  - Shifted enables: 8-bit `{4'b0, mask} << off`.
  - Beat0 takes the low halves. Beat1 takes the high halves.
- **Split rule.** A second beat is needed when the high half of the shifted enables is nonzero.
  - Half at off 3 splits.
  - Word at off 1, 2 or 3 splits.
  - Byte never splits.
- **Beat addresses.**
  - Beat0: `addr & ~3`.
  - Beat1: `(addr & ~3) + 4`, wrapping to 0 at the top of the address space.
- **FSM states.**
  - IDLE: `req_ready` = 1. On handshake go to WR0, or to ERR if size = 11.
  - WR0: drive beat0. On `mem_ack`, go to WR1 if split, else to FIN.
  - WR1: drive beat1. On `mem_ack`, go to FIN.
  - FIN: pulse `done`. `req_ready` = 0. Next state IDLE.
  - ERR: pulse `done` and `err`. No memory write. Next state IDLE.
- **Reset.**
  - Asserting `rst_n` low at any time aborts the operation. FSM goes to IDLE and the captured request is discarded.
  - A pending second beat is never issued.
  - All outputs are 0 during reset, except `req_ready`, which is 0 during reset and 1 in the first cycle after release.

## Timing
- **Reset values:** `mem_wr_en` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_be` = 0, `done` = 0, `err` = 0, `req_ready` = 0. All outputs are registered.
- **Beat timing.**
  - Handshake at cycle T puts the unit in WR0 at T+1.
  - `mem_wr_en` = 1 with beat0 values at T+1.
  - A beat completes in the cycle where `mem_wr_en && mem_ack`. An ack in the same cycle the beat is first presented counts.
- **Stalls.** While `mem_ack` = 0, `mem_wr_en`, `mem_addr`, `mem_wdata` and `mem_be` are held stable indefinitely.
- **Between beats.** `mem_wr_en` falls in the cycle after the final ack. Between beat0 ack and beat1 there are 0 idle cycles: beat1 is presented in the cycle after the beat0 ack.
- **Latency with zero-wait memory.**
  - Unsplit: `done` at T+2, next accept at T+3.
  - Split: `done` at T+3, next accept at T+4.
  - Reserved size: `done` and `err` at T+1, next accept at T+2.
- **Ignored inputs.** `mem_ack` outside WR0/WR1 is ignored. `req_valid` while `req_ready` = 0 is ignored, not queued.

## Test plan
- **Byte store.** addr 0x1002, data 0x123456AB, size 00, ack immediate -> one beat: `mem_addr` 0x1000, `mem_be` 0100, `mem_wdata` 0x00AB0000; `done` at T+2.
- **Misaligned word.** addr 0x1003, data 0xAABBCCDD, size 10 -> two beats:
  - beat0: 0x1000 / be 1000 / 0xDD000000
  - beat1: 0x1004 / be 0111 / 0x00AABBCC
  - `done` at T+3.
- **Split half with stall.** addr 0x2003, data 0xFFFFBEEF, size 01, `mem_ack` held low for 3 cycles on beat0 -> beat0 0x2000 / be 1000 / 0xEF000000 stays stable for 4 cycles; then beat1 0x2004 / be 0001 / 0x000000BE.
- **Address wrap.** addr 0xFFFFFFFE, data 0x11223344, size 10 -> two beats:
  - beat0: 0xFFFFFFFC / be 1100 / 0x33440000
  - beat1: 0x00000000 / be 0011 / 0x00001122
- **Reserved size.** size 11 -> `mem_wr_en` never asserted; `done` = `err` = 1 at T+1 only; `req_ready` back to 1 at T+2.
- **Reset mid-operation.** Split word store with `rst_n` pulsed low during the beat0 stall -> all outputs go to 0 asynchronously, no beat1 is issued, `req_ready` = 1 in the first cycle after release, and the next request completes normally.
